move_sequencer: RTL
===================

// Module: move_sequencer
// PURPOSE
//  Turns the 11-bit gamepad vector from the controller reader into a paced stream of robot move commands.
//  Arbitrates between two command sources, the manual gamepad and an autonomous cleaning-path source.
//  Issues at most one command per frame window to the robot motion datapath over a valid/ready handshake.
//  Sits between the controller reader / auto-path generator and the robot position/clean datapath.
// PARAMETERS
//  REPEAT_FRAMES  8   frames a direction must be held before it auto-repeats (1..255)
//  GAP_FRAMES     2   minimum frames between two accepted commands (0..255)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  vga_vs     in   1   VGA vertical sync, level; rising edge = frame tick
//  buttons    in   11  [0]up [1]down [2]left [3]right [4]a [5]b [6]c [7]start [8]x [9]y [10]z, 1=pressed
//  auto_req   in   1   auto source has a command pending; held until auto_ack
//  auto_cmd   in   3   auto command, same encoding as cmd; stable while auto_req=1
//  auto_ack   out  1   one-cycle pulse when the auto command is accepted downstream
//  cmd_valid  out  1   command offered to datapath
//  cmd        out  3   0 NOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 CLEAN; 6-7 reserved
//  cmd_ready  in   1   datapath accepts cmd when cmd_valid & cmd_ready
//  mode_auto  out  1   0 manual, 1 autonomous
// BEHAVIOUR
//  Reset values: auto_ack=0, cmd_valid=0, cmd=0, mode_auto=0, FSM=IDLE, all counters=0, edge registers=0.
//  Frame tick: vga_vs registered once; tick = vs & ~vs_q, one cycle wide. Buttons are sampled only on tick.
//  Press edge: per-bit pressed & ~pressed_at_previous_tick.
//  Mode: start press edge toggles mode_auto on the tick it is seen. In auto mode a b press edge forces mode_auto=0.
//   A mode change while in ISSUE takes effect only after the handshake completes.
//  Manual select, on tick, mode_auto=0. Priority up>down>left>right>a(CLEAN); lower-priority presses are ignored.
//   A press edge selects immediately. A held direction is handled by the optional feature below.
//   c, x, y and z are ignored.
//  Auto select: in IDLE with mode_auto=1 and auto_req=1, take auto_cmd (no tick needed). A cmd of 0, 6 or 7 is acked and dropped with no cmd_valid.
//   auto_req is ignored while mode_auto=0.
//  FSM
//   IDLE     -> ISSUE on a selected command: cmd and cmd_valid are registered, so cmd_valid rises 1 cycle after the select.
//   ISSUE    cmd_valid=1 and cmd is held stable until cmd_ready.
//            On handshake: cmd_valid=0 next cycle; auto_ack pulses the same next cycle if the source was auto.
//            Goes to GAP, or to IDLE when GAP_FRAMES=0.
//   GAP      count ticks; after GAP_FRAMES ticks -> IDLE. Ticks seen in GAP still update press-edge history (no presses lost).
//  A press edge seen in ISSUE/GAP is latched as pending (one slot, highest priority wins) and issued from IDLE.
//  Simultaneous tick and auto_req in IDLE, auto mode: auto wins. Manual is not selectable in auto mode.
//  Reset mid-ISSUE: cmd_valid drops the cycle after reset and the pending command is discarded; no auto_ack.
//  Counters saturate and never wrap.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   A direction held continuously for REPEAT_FRAMES ticks since its press edge or last issue re-selects itself.
//   Counter clears on release or when priority moves to another direction. CLEAN (a) never repeats.
//  AUTO_REPEAT_EN undefined: only press edges generate manual commands; the repeat counter is not built.
// TESTING
//  Reset held 2 cycles with up held and vga_vs toggling -> cmd_valid=0, cmd=0, mode_auto=0 during and after reset.
//  up pressed before a tick, cmd_ready=1 -> cmd_valid high 1 cycle after tick, cmd=1, exactly one command.
//  up+left pressed, cmd_ready=0 for 5 cycles -> cmd=1 held stable with valid all 5 cycles; accepted on the 6th; then GAP for 2 ticks.
//  start edge, then auto_req=1 with auto_cmd=4 -> mode_auto=1, cmd=4 issued, auto_ack single pulse, then b edge -> mode_auto=0.
//  AUTO_REPEAT_EN, right held 20 ticks, GAP_FRAMES=2 -> commands at the press tick, +8, +16 (3 total).
//    Undefined -> 1 total.
//  auto_cmd=7 with auto_req=1 -> auto_ack pulse, cmd_valid stays 0.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: paces gamepad / autonomous-path move commands onto a
// valid/ready link toward the robot motion datapath, at most one per frame gap.
// Optional feature macro: AUTO_REPEAT_EN (held-direction auto-repeat).
module move_sequencer #(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned GAP_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_vs,
  input  logic [10:0] buttons,
  input  logic        auto_req,
  input  logic [2:0]  auto_cmd,
  output logic        auto_ack,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  input  logic        cmd_ready,
  output logic        mode_auto
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_CLEAN = 3'd5;
  localparam logic [8:0] GAP_LIM   = 9'(GAP_FRAMES);
  localparam logic [8:0] REP_LIM   = 9'(REPEAT_FRAMES);

  state_t      r_state;
  logic        r_vs_q;
  logic [6:0]  r_btn_prev;
  logic        r_mode_tgt;
  logic        r_mode;
  logic        r_valid;
  logic [2:0]  r_cmd;
  logic        r_ack;
  logic        r_src_auto;
  logic [4:0]  r_pend;
  logic [7:0]  r_gap_cnt;

  logic        w_tick;
  logic [6:0]  w_btn;
  logic [6:0]  w_edge;
  logic        w_mode_nxt;
  logic        w_handshake;
  logic [4:0]  w_rep;
  logic [4:0]  w_man;
  logic [4:0]  w_man_req;
  logic [8:0]  w_gap_inc;
  logic        w_auto_ok;
  logic        w_unused_btn;

  // Only up/down/left/right/a/b/start matter; bit 6 = start, bit 5 = b.
  assign w_btn        = {buttons[7], buttons[5:0]};
  assign w_unused_btn = ^{buttons[10:8], buttons[6]};
  assign w_tick       = vga_vs & ~r_vs_q;
  assign w_edge       = w_btn & ~r_btn_prev;
  assign w_handshake  = r_valid & cmd_ready;
  assign w_man        = w_tick ? (w_edge[4:0] | w_rep) : '0;
  assign w_man_req    = r_pend | w_man;
  assign w_gap_inc    = {1'b0, r_gap_cnt} + 9'd1;
  assign w_auto_ok    = (auto_cmd >= 3'd1) && (auto_cmd <= CMD_CLEAN);

  assign auto_ack  = r_ack;
  assign cmd_valid = r_valid;
  assign cmd       = r_cmd;
  assign mode_auto = r_mode;

  function automatic logic [2:0] f_pick(input logic [4:0] m);
    if (m[0])      return 3'd1;
    else if (m[1]) return 3'd2;
    else if (m[2]) return 3'd3;
    else if (m[3]) return 3'd4;
    else if (m[4]) return 3'd5;
    else           return CMD_NOP;
  endfunction

  // Frame-tick detection and button history sampled once per tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_q     <= 1'b0;
      r_btn_prev <= '0;
    end else begin
      r_vs_q <= vga_vs;
      if (w_tick) r_btn_prev <= w_btn;
    end
  end

  // Requested mode follows start/b edges; what is visible is frozen while a command is offered.
  always_comb begin
    w_mode_nxt = r_mode_tgt;
    if (w_tick && w_edge[6])                    w_mode_nxt = ~r_mode_tgt;
    else if (w_tick && w_edge[5] && r_mode_tgt) w_mode_nxt = 1'b0;
  end

  // Mode register pair: target tracks presses, mode_auto lags it across an open handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_tgt <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      r_mode_tgt <= w_mode_nxt;
      if (r_state != S_ISSUE || w_handshake) r_mode <= w_mode_nxt;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [3:0] r_rep_dir;
  logic [7:0] r_rep_cnt;
  logic [3:0] w_held;
  logic [8:0] w_rep_inc;
  logic       w_rep_hit;

  assign w_rep_inc = {1'b0, r_rep_cnt} + 9'd1;
  assign w_rep_hit = w_tick && (w_held != '0) && (w_held == r_rep_dir) && (w_rep_inc >= REP_LIM);
  assign w_rep     = w_rep_hit ? {1'b0, w_held} : '0;

  // Highest-priority direction currently held, one-hot.
  always_comb begin
    w_held = '0;
    if (buttons[0])      w_held = 4'b0001;
    else if (buttons[1]) w_held = 4'b0010;
    else if (buttons[2]) w_held = 4'b0100;
    else if (buttons[3]) w_held = 4'b1000;
  end

  // Per-tick hold counter; restarts on release, on a priority change, or after firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_dir <= '0;
      r_rep_cnt <= '0;
    end else if (w_tick) begin
      if (w_held == '0 || w_held != r_rep_dir) begin
        r_rep_dir <= w_held;
        r_rep_cnt <= '0;
      end else if (w_rep_inc >= REP_LIM) begin
        r_rep_cnt <= '0;
      end else if (r_rep_cnt != '1) begin
        r_rep_cnt <= r_rep_cnt + 8'd1;
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^REP_LIM;
  assign w_rep        = '0;
`endif

  // Command FSM: select in IDLE, hold offer in ISSUE, pace in GAP; manual presses during busy are pended.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_cmd      <= CMD_NOP;
      r_ack      <= 1'b0;
      r_src_auto <= 1'b0;
      r_pend     <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_mode) begin
            r_pend <= '0;
            // r_ack blocks re-taking the same request in the cycle it is being acknowledged.
            if (auto_req && !r_ack) begin
              if (w_auto_ok) begin
                r_cmd      <= auto_cmd;
                r_valid    <= 1'b1;
                r_src_auto <= 1'b1;
                r_state    <= S_ISSUE;
              end else begin
                r_ack <= 1'b1;
              end
            end
          end else if (w_man_req != '0) begin
            r_cmd      <= f_pick(w_man_req);
            r_valid    <= 1'b1;
            r_src_auto <= 1'b0;
            r_pend     <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_pend <= r_mode ? '0 : w_man_req;
          if (w_handshake) begin
            r_valid   <= 1'b0;
            r_cmd     <= CMD_NOP;
            r_ack     <= r_src_auto;
            r_gap_cnt <= '0;
            r_state   <= (GAP_LIM == 9'd0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          r_pend <= r_mode ? '0 : w_man_req;
          if (w_tick) begin
            if (w_gap_inc >= GAP_LIM) r_state <= S_IDLE;
            if (r_gap_cnt != '1) r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
